// File: rtl/seg_pwr_seq_pkg.sv
// Shared types and constants for the Segway power-up / soft-start sequencer.
// Optional feature macro: SEG_SEQ_DECAY_EN (adds the DECAY ramp-down state).
package seg_pkg;

`ifdef SEG_SEQ_DECAY_EN
  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RAMP  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DECAY = 2'd3
  } seq_state_t;
`else
  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RAMP = 2'd1,
    ST_RUN  = 2'd2
  } seq_state_t;
`endif

  localparam logic [7:0] SS_MAX = 8'hFF;
  localparam logic [7:0] SS_MIN = 8'h00;

endpackage

// File: rtl/seg_pwr_seq_if.sv
// Control bundle between rider/steering logic, the sequencer and the torque math.
// master = the side issuing requests and samples, slave = the sequencer.
interface seg_pwr_seq_if;
  logic       pwr_req;
  logic       steer_req;
  logic       vld;
  logic       too_fast;
  logic       pwr_up;
  logic [7:0] ss_tmr;
  logic       en_steer;
  logic       fault;

  modport master (
    output pwr_req, steer_req, vld, too_fast,
    input  pwr_up, ss_tmr, en_steer, fault
  );

  modport slave (
    input  pwr_req, steer_req, vld, too_fast,
    output pwr_up, ss_tmr, en_steer, fault
  );
endinterface

// File: rtl/seg_prescaler.sv
// Wrapping 0..DIV-1 counter that paces ss_tmr steps in both ramp directions.
// tick is high for the single cycle the count sits at DIV-1.
module seg_prescaler #(
  parameter int DIV = 512
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  // Next count: synchronous clear wins, otherwise wrap at DIV-1.
  always_comb begin
    if (clr)       cnt_d = '0;
    else if (tick) cnt_d = '0;
    else           cnt_d = cnt_q + CW'(1);
  end

  // Count register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/seg_pwr_seq.sv
// Power-up and soft-start sequencer: OFF -> RAMP -> RUN, with a sticky over-speed
// fault that either ramps the drive down (SEG_SEQ_DECAY_EN defined, DECAY state)
// or cuts it straight to OFF (macro undefined). Dropping pwr_req always wins.
module seg_pwr_seq
  import seg_pkg::*;
#(
  parameter int RAMP_DIV   = 512,
  parameter int FAST_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  seg_pwr_seq_if.slave bus
);

`ifdef SEG_SEQ_DECAY_EN
  localparam seq_state_t FAULT_DEST = ST_DECAY;
`else
  localparam seq_state_t FAULT_DEST = ST_OFF;
`endif

  seq_state_t state_q, state_d;
  logic [7:0] ss_tmr_q, ss_tmr_d;
  logic [3:0] fast_cnt_q, fast_cnt_d;
  logic       fault_q, fault_d;
  logic       pwr_up_q, pwr_up_d;
  logic       en_steer_q, en_steer_d;

  logic       tick;
  logic       pre_clr;
  logic       active;
  logic       trip;
  logic [3:0] fast_inc;
  logic [7:0] ss_inc;
`ifdef SEG_SEQ_DECAY_EN
  logic [7:0] ss_dec;
  assign ss_dec = ss_tmr_q - 8'd1;
`endif

  // The over-speed watchdog only runs while torque is being delivered up or at full scale.
  assign active   = (state_q == ST_RAMP) || (state_q == ST_RUN);
  assign fast_inc = fast_cnt_q + 4'd1;
  assign trip     = active && bus.vld && bus.too_fast && (fast_inc == 4'(FAST_LIMIT));
  assign ss_inc   = ss_tmr_q + 8'd1;

  // Restart the step timer on every state change so each ramp phase begins a full step.
  assign pre_clr = (state_d != state_q) || (state_q == ST_OFF) || (state_q == ST_RUN);

  seg_prescaler #(.DIV(RAMP_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (pre_clr),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_OFF;
    else        state_q <= state_d;
  end

  // Next-state logic; losing pwr_req overrides everything, a fault overrides ramp completion.
  always_comb begin
    // NOTE: default every comb output first so no path leaves it unassigned (no latch).
    state_d = state_q;
    if (!bus.pwr_req) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF:  if (!fault_q) state_d = ST_RAMP;
        ST_RAMP: begin
          if (trip)                           state_d = FAULT_DEST;
          else if (tick && ss_inc == SS_MAX)  state_d = ST_RUN;
        end
        ST_RUN:  if (trip) state_d = FAULT_DEST;
`ifdef SEG_SEQ_DECAY_EN
        ST_DECAY: begin
          if (ss_tmr_q == SS_MIN || (tick && ss_dec == SS_MIN)) state_d = ST_OFF;
        end
`endif
        default: state_d = ST_OFF;
      endcase
    end
  end

  // Soft-start scale, over-speed streak counter and sticky fault.
  always_comb begin
    ss_tmr_d   = ss_tmr_q;
    fast_cnt_d = fast_cnt_q;
    fault_d    = fault_q;

    if (!bus.pwr_req) fault_d = 1'b0;
    else if (trip)    fault_d = 1'b1;

    if (active && bus.vld) fast_cnt_d = bus.too_fast ? fast_inc : 4'd0;

    case (state_d)
      ST_OFF: begin
        ss_tmr_d   = SS_MIN;
        fast_cnt_d = 4'd0;
      end
      ST_RAMP: begin
        if (state_q != ST_RAMP) begin
          ss_tmr_d   = SS_MIN;
          fast_cnt_d = 4'd0;
        end else if (tick) begin
          ss_tmr_d = ss_inc;
        end
      end
      ST_RUN: ss_tmr_d = SS_MAX;
`ifdef SEG_SEQ_DECAY_EN
      // Entry holds the current level; the exit to OFF at zero keeps this from underflowing.
      ST_DECAY: if (state_q == ST_DECAY && tick) ss_tmr_d = ss_dec;
`endif
      default: ;
    endcase
  end

  // Output decode from the upcoming state so the flops present it with one-cycle latency.
  always_comb begin
    pwr_up_d   = (state_d != ST_OFF);
    en_steer_d = (state_d == ST_RUN) && bus.steer_req;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_tmr_q   <= SS_MIN;
      fast_cnt_q <= 4'd0;
      fault_q    <= 1'b0;
      pwr_up_q   <= 1'b0;
      en_steer_q <= 1'b0;
    end else begin
      ss_tmr_q   <= ss_tmr_d;
      fast_cnt_q <= fast_cnt_d;
      fault_q    <= fault_d;
      pwr_up_q   <= pwr_up_d;
      en_steer_q <= en_steer_d;
    end
  end

  assign bus.pwr_up   = pwr_up_q;
  assign bus.ss_tmr   = ss_tmr_q;
  assign bus.en_steer = en_steer_q;
  assign bus.fault    = fault_q;

endmodule

// File: tb/tb_seg_pwr_seq.sv
// Self-checking bench for seg_pwr_seq: directed scenarios plus random stimulus,
// all outputs compared every cycle against a time-based behavioural model.
module tb_seg_pwr_seq;
  localparam int RAMP_DIV   = 4;
  localparam int FAST_LIMIT = 4;
`ifdef SEG_SEQ_DECAY_EN
  localparam bit DECAY_BUILD = 1'b1;
`else
  localparam bit DECAY_BUILD = 1'b0;
`endif

  localparam int M_OFF = 0, M_RAMP = 1, M_RUN = 2, M_DECAY = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 1'b0;

  seg_pwr_seq_if bus ();

  seg_pwr_seq #(.RAMP_DIV(RAMP_DIV), .FAST_LIMIT(FAST_LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Level is derived from elapsed time in the phase: ramp level = t/DIV,
  // decay level = start - t/DIV; the streak counts consecutive too_fast samples.
  int m_mode = M_OFF;
  int m_t = 0;
  int m_start = 0;
  int m_streak = 0;
  int m_ss = 0;
  bit m_fault = 1'b0;
  bit m_steer = 1'b0;
  bit m_trip;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_OFF; m_t = 0; m_start = 0; m_streak = 0;
      m_ss = 0; m_fault = 1'b0; m_steer = 1'b0;
    end else begin
      m_trip = (m_mode == M_RAMP || m_mode == M_RUN) && bus.vld && bus.too_fast
               && (m_streak + 1 >= FAST_LIMIT);
      if (!bus.pwr_req) begin
        m_mode = M_OFF; m_fault = 1'b0; m_streak = 0;
      end else begin
        if ((m_mode == M_RAMP || m_mode == M_RUN) && bus.vld)
          m_streak = bus.too_fast ? m_streak + 1 : 0;
        case (m_mode)
          M_OFF: if (!m_fault) begin m_mode = M_RAMP; m_t = 0; m_streak = 0; end
          M_RAMP, M_RUN: begin
            if (m_trip) begin
              m_fault = 1'b1;
              if (DECAY_BUILD) begin m_mode = M_DECAY; m_t = 0; m_start = m_ss; end
              else begin m_mode = M_OFF; m_streak = 0; end
            end else if (m_mode == M_RAMP) begin
              m_t++;
              if (m_t / RAMP_DIV >= 255) m_mode = M_RUN;
            end
          end
          default: begin
            if (m_start - m_t / RAMP_DIV <= 0) begin
              m_mode = M_OFF; m_streak = 0;
            end else begin
              m_t++;
              if (m_start - m_t / RAMP_DIV <= 0) begin m_mode = M_OFF; m_streak = 0; end
            end
          end
        endcase
      end
      case (m_mode)
        M_OFF:   m_ss = 0;
        M_RAMP:  m_ss = m_t / RAMP_DIV;
        M_RUN:   m_ss = 255;
        default: m_ss = m_start - m_t / RAMP_DIV;
      endcase
      m_steer = (m_mode == M_RUN) && bus.steer_req;
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_pwr_up",   {31'd0, bus.pwr_up},   {31'd0, m_mode != M_OFF});
      check("cyc_ss_tmr",   {24'd0, bus.ss_tmr},   m_ss);
      check("cyc_en_steer", {31'd0, bus.en_steer}, {31'd0, m_steer});
      check("cyc_fault",    {31'd0, bus.fault},    {31'd0, m_fault});
    end
  end

  // ---------------- stimulus ----------------
  // Apply inputs just after a falling edge; return at the next falling edge.
  task automatic step(input logic p, input logic s, input logic v, input logic tf);
    bus.pwr_req = p; bus.steer_req = s; bus.vld = v; bus.too_fast = tf;
    @(negedge clk);
  endtask

  task automatic steps(input int n, input logic p, input logic s);
    for (int i = 0; i < n; i++) step(p, s, 1'b0, 1'b0);
  endtask

  initial begin
    int cnt;
    int tf_pct;
    bus.pwr_req = 1'b0; bus.steer_req = 1'b0; bus.vld = 1'b0; bus.too_fast = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_pwr_up", {31'd0, bus.pwr_up}, 32'd0);
    check("rst_ss_tmr", {24'd0, bus.ss_tmr}, 32'd0);
    check("rst_fault",  {31'd0, bus.fault},  32'd0);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    steps(2, 1'b0, 1'b0);

    // Power-up and full ramp; steer_req held high must not leak into RAMP.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("pwr_up_latency", {31'd0, bus.pwr_up}, 32'd1);
    check("ramp_start_ss",  {24'd0, bus.ss_tmr}, 32'h00);
    steps(4, 1'b1, 1'b1);
    check("ramp_first_step", {24'd0, bus.ss_tmr}, 32'h01);
    check("model_first_step", m_ss, 32'h01);
    check("ramp_no_steer", {31'd0, bus.en_steer}, 32'd0);
    steps(1015, 1'b1, 1'b1);
    check("ramp_1019_ss", {24'd0, bus.ss_tmr}, 32'hFE);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("run_entry_ss", {24'd0, bus.ss_tmr}, 32'hFF);
    check("run_entry_steer", {31'd0, bus.en_steer}, 32'd1);
    check("model_run", m_mode, M_RUN);

    // Steering follows steer_req with one cycle of delay.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("steer_0", {31'd0, bus.en_steer}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("steer_1", {31'd0, bus.en_steer}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("steer_0b", {31'd0, bus.en_steer}, 32'd0);

    // Over-speed: a broken streak must not fault, an unbroken one of FAST_LIMIT must.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
    check("streak_broken_no_fault", {31'd0, bus.fault}, 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check("fault_set", {31'd0, bus.fault}, 32'd1);
    if (DECAY_BUILD) begin
      check("decay_pwr_up", {31'd0, bus.pwr_up}, 32'd1);
      check("decay_entry_ss", {24'd0, bus.ss_tmr}, 32'hFF);
      steps(RAMP_DIV, 1'b1, 1'b0);
      check("decay_first_step", {24'd0, bus.ss_tmr}, 32'hFE);
      cnt = 0;
      while (bus.pwr_up && cnt < 1100) begin
        step(1'b1, 1'b0, 1'b0, 1'b0);
        cnt++;
      end
      check("decay_reaches_off", {31'd0, bus.pwr_up}, 32'd0);
      check("decay_cycles", cnt, 255 * RAMP_DIV - RAMP_DIV);
      check("decay_off_ss", {24'd0, bus.ss_tmr}, 32'h00);
    end else begin
      check("nodecay_pwr_off", {31'd0, bus.pwr_up}, 32'd0);
      check("nodecay_ss_zero", {24'd0, bus.ss_tmr}, 32'h00);
    end

    // Sticky fault holds OFF until pwr_req drops.
    steps(5, 1'b1, 1'b0);
    check("fault_hold_off", {31'd0, bus.pwr_up}, 32'd0);
    check("fault_sticky", {31'd0, bus.fault}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("fault_cleared", {31'd0, bus.fault}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("restart_pwr_up", {31'd0, bus.pwr_up}, 32'd1);
    check("restart_ss", {24'd0, bus.ss_tmr}, 32'h00);

    // Mid-ramp: pwr_req drop coinciding with the FAST_LIMIT-th sample wins.
    steps(256, 1'b1, 1'b0);
    check("mid_ramp_ss", {24'd0, bus.ss_tmr}, 32'h40);
    for (int i = 0; i < FAST_LIMIT - 1; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("drop_prio_pwr", {31'd0, bus.pwr_up}, 32'd0);
    check("drop_prio_fault", {31'd0, bus.fault}, 32'd0);
    check("drop_prio_ss", {24'd0, bus.ss_tmr}, 32'h00);

    // Randomized traffic, alternating calm and over-speed-heavy blocks.
    for (int blk = 0; blk < 40; blk++) begin
      tf_pct = (blk % 2 == 0) ? 10 : 60;
      for (int i = 0; i < 400; i++)
        step(($urandom_range(0, 2999) != 0), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) < tf_pct));
    end

    // Asynchronous reset mid-RUN.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    steps(255 * RAMP_DIV + 2, 1'b1, 1'b1);
    check("pre_reset_run_ss", {24'd0, bus.ss_tmr}, 32'hFF);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pwr_up", {31'd0, bus.pwr_up}, 32'd0);
    check("async_rst_ss", {24'd0, bus.ss_tmr}, 32'h00);
    check("async_rst_steer", {31'd0, bus.en_steer}, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    steps(3, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
